// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and load/store traffic onto one byte-wide RAM port,
// keeping the last fetched word in a one-entry fetch buffer.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  if_flush,
    output logic                  if_done,
    output logic [31:0]           if_inst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [2:0]            mem_len,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);
    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;
    state_t                  state;
    logic [2:0]              cnt, len, cnt1;
    logic [1:0]              bi;
    logic [ADDR_WIDTH-1:0]   base, buf_tag, nxt_a;
    logic [31:0]             asm_q, asm_nxt, buf_inst;
    logic                    buf_valid, wr_hit, hit_now;

    assign if_done = if_req & buf_valid & (buf_tag == if_pc);
    assign if_inst = if_done ? buf_inst : '0;
    assign cnt1    = cnt + 3'd1;
    assign bi      = 2'(cnt - 3'd1);
    assign nxt_a   = base + ADDR_WIDTH'(cnt1);
    assign hit_now = ram_a[ADDR_WIDTH-1:2] == buf_tag[ADDR_WIDTH-1:2];

    // In read states, cnt = k means ram_din carries byte k-1 this cycle
    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[{bi, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            len       <= '0;
            base      <= '0;
            asm_q     <= '0;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_inst  <= '0;
            wr_hit    <= 1'b0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (mem_req && !mem_done) begin
                        state    <= mem_we ? MEM_WR : MEM_RD;
                        base     <= mem_addr;
                        len      <= mem_len;
                        ram_a    <= mem_addr;
                        ram_wr   <= mem_we;
                        ram_dout <= mem_we ? mem_wdata[7:0] : 8'h00;
                        asm_q    <= mem_we ? mem_wdata >> 8 : 32'h0;
                        wr_hit   <= 1'b0;
                    end else if (if_req && !if_done && !if_flush) begin
                        state <= IF_RD;
                        base  <= if_pc;
                        len   <= 3'd4;
                        ram_a <= if_pc;
                        asm_q <= '0;
                    end
                end
                IF_RD, MEM_RD: begin
                    cnt   <= cnt1;
                    ram_a <= (cnt1 < len) ? nxt_a : '0;
                    if (cnt != 3'd0)
                        asm_q <= asm_nxt;
                    if (state == IF_RD && if_flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                        ram_a <= '0;
                    end else if (cnt == len) begin
                        state <= IDLE;
                        cnt   <= '0;
                        if (state == IF_RD) begin
                            buf_valid <= 1'b1;
                            buf_tag   <= base;
                            buf_inst  <= asm_nxt;
                        end else begin
                            mem_done  <= 1'b1;
                            mem_rdata <= asm_nxt;
                        end
                    end
                end
                MEM_WR: begin
                    wr_hit <= wr_hit | hit_now;
                    if (cnt1 == len) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        ram_a    <= '0;
                        ram_wr   <= 1'b0;
                        ram_dout <= '0;
                        mem_done <= 1'b1;
                        if (wr_hit || hit_now)
                            buf_valid <= 1'b0;
                    end else begin
                        cnt      <= cnt1;
                        ram_a    <= nxt_a;
                        ram_dout <= asm_q[7:0];
                        asm_q    <= asm_q >> 8;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the pipeline and the single byte-wide unified RAM port. It serves two clients: the instruction-fetch stage (4-byte fetch at a PC) and the memory stage (1/2/4-byte load/store). Fetched words are held in a one-entry fetch buffer; `if_done` is a combinational hit against it, and the fetch stage stalls on that signal. Memory-stage requests take priority over fetches, and a fetch can be aborted by a pipeline flush.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of all byte addresses.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `if_req`  in  1  fetch stage requests the instruction at `if_pc`
- `if_pc`  in  ADDR_WIDTH  fetch address, 4-byte aligned
- `if_flush`  in  1  abort the in-flight fetch (branch redirect)
- `if_done`  out  1  fetch buffer holds the word for `if_pc`
- `if_inst`  out  32  fetched word when `if_done`, else 0
- `mem_req`  in  1  load/store request; held high until `mem_done`
- `mem_we`  in  1  1 = store, 0 = load
- `mem_addr`  in  ADDR_WIDTH  byte address
- `mem_len`  in  3  byte count: 1, 2 or 4 only
- `mem_wdata`  in  32  store data; byte k = bits [8k+7:8k]
- `mem_done`  out  1  one-cycle completion pulse
- `mem_rdata`  out  32  load data, zero-extended, valid while `mem_done`
- `ram_a`  out  ADDR_WIDTH  RAM byte address
- `ram_wr`  out  1  RAM write enable
- `ram_dout`  out  8  RAM write byte
- `ram_din`  in  8  RAM read byte: the byte at the `ram_a` presented in cycle c is valid in cycle c+1

## Operation
- The state machine has four states: IDLE, IF_RD, MEM_RD and MEM_WR. It keeps a byte counter `cnt` (0..4), a latched base address and length, a 32-bit assembly register, and a fetch buffer made of `buf_valid`, `buf_tag` and `buf_inst`.
- Hit logic: `if_done = if_req & buf_valid & (buf_tag == if_pc)` (combinational). `if_inst = if_done ? buf_inst : 0`.
- Arbitration (evaluated in IDLE only):
  - If `mem_req` is high and `mem_done` is low, go to MEM_WR or MEM_RD, selected by `mem_we`.
  - Otherwise, if `if_req` is high, the fetch buffer misses and `if_flush` is low, go to IF_RD.
  - Otherwise stay in IDLE.
  - `mem_req` is ignored in the cycle in which `mem_done` is high, so a completed request cannot restart.
- Byte order is little-endian. Byte k of an access goes to address base+k.
- IF_RD:
  - Read 4 bytes.
  - On completion, load `buf_tag` = base and `buf_inst` = assembled word, set `buf_valid`, and return to IDLE.
- MEM_RD:
  - Read `mem_len` bytes. Unused upper bytes of the result are 0.
  - Pulse `mem_done` with `mem_rdata`, then return to IDLE.
- MEM_WR:
  - Write `mem_len` bytes from `mem_wdata`, then pulse `mem_done`.
  - If any byte written falls in the same 4-byte word as `buf_tag`, clear `buf_valid` when the write completes.
- `if_flush` in IF_RD: return to IDLE at the next edge. The fetch buffer is not updated. Bytes already returned are discarded.
- `if_flush` has no effect on MEM_RD or MEM_WR, or on a fetch buffer that is already valid.
- Reset (asynchronous, at any time):
  - state = IDLE, `cnt` = 0, `buf_valid` = 0, and all buffer and assembly registers = 0.
  - Outputs: `ram_a` = 0, `ram_wr` = 0, `ram_dout` = 0, `mem_done` = 0, `mem_rdata` = 0.
  - `if_done` = 0 follows from `buf_valid` = 0.

## Timing
- `ram_a`, `ram_wr`, `ram_dout`, `mem_done` and `mem_rdata` are registered outputs. In IDLE: `ram_a` = 0 and `ram_wr` = 0.
- Request accepted in IDLE at cycle 0 means address byte k is presented in cycle 1+k.
- Reads: byte k is captured from `ram_din` in cycle 2+k.
- IF_RD latency:
  - Addresses are presented in cycles 1–4 and bytes captured in cycles 2–5.
  - The buffer is written at the end of cycle 5, so `if_done` is high in cycle 6. A fetch miss costs 6 cycles.
- MEM_RD: `mem_done` is high in cycle `mem_len`+2 (cycle 3, 4 or 6). The controller is in IDLE in that cycle.
- MEM_WR: `ram_wr` is high in cycles 1..`mem_len`. `mem_done` is high in cycle `mem_len`+1 and `ram_wr` is 0 in that cycle.
- `mem_done` is exactly one cycle wide. The next request can be accepted in the cycle after `mem_done`.
- A flush asserted in IF_RD cycle c gives IDLE in cycle c+1 with `ram_a` = 0. In that IDLE cycle a new fetch for the redirected `if_pc` can be accepted if `if_flush` is low.
- `mem_req` and `if_req` are both high in IDLE with a buffer miss: the memory request wins and the fetch starts after `mem_done`.

## Test plan
- Fetch miss: RAM[0x100..0x103] = 13,05,10,00; `if_req` high, `if_pc` = 0x100 → `ram_a` = 0x100..0x103 in cycles 1–4; `if_done` = 1 and `if_inst` = 0x00100513 in cycle 6. Holding the same pc keeps `if_done` = 1 with no further RAM traffic.
- Load half: RAM[0x2001] = 0xFE, RAM[0x2002] = 0x80; `mem_len` = 2, `mem_addr` = 0x2001 → `mem_done` pulse in cycle 4 with `mem_rdata` = 0x000080FE; the held `mem_req` does not restart the load.
- Store word: `mem_addr` = 0x100, `mem_wdata` = 0xDEADBEEF → `ram_wr` = 1 with bytes EF,BE,AD,DE in cycles 1–4, `mem_done` in cycle 5, and `buf_valid` cleared if `buf_tag` = 0x100.
- Contention: `if_req` (miss) and `mem_req` (load, len 1) arrive together → load completes (`mem_done` in cycle 3), then the fetch starts and `if_done` follows 6 cycles after the fetch is accepted.
- Flush: `if_flush` pulses in fetch cycle 3 → IDLE next cycle, buffer unchanged, new `if_pc` = 0x200 fetched and `if_inst` matches RAM[0x200..0x203].
- Reset: `rst_n` low in MEM_WR cycle 2 → immediately `ram_wr` = 0, `ram_a` = 0, `mem_done` = 0, `if_done` = 0; after release the controller accepts a new request from IDLE.
